sync_upcnt_tff: RTL
===================

Name: sync_upcnt_tff

Overview:
- Synchronous N-bit modulo-MOD up counter built from an array of T flip-flop cells sharing one clock.
- Counts in the opposite direction to the team's ripple down-counter, with no ripple: every bit changes on the same clk edge.
- Provides enable, parallel load, a cascade carry output and a registered wrap pulse.
- Serves as the glitch-free counting primitive for timers and dividers in the counter library.

Parameters:
- WIDTH, 4, counter width in bits (≥1).
- MOD, 16, count modulus, 2 ≤ MOD ≤ 2^WIDTH; count sequence is 0..MOD-1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; advances count by 1 per clk when high.
- load  input  1  synchronous parallel load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal-count carry, combinational: en & (q == MOD-1); for cascading the next stage's en.
- wrap  output  1  registered one-cycle pulse, high in the cycle after q wrapped MOD-1→0.

Behaviour:
- Reset: on a clk edge with rst=1, q←0 and wrap←0, overriding load and en.
- Priority per edge: rst > load > en > hold.
- Every state bit is a T-FF cell, next = q ^ t. No bit may be clocked by another bit's output. The T vector is computed combinationally:
  - load: t = q ^ load_v, where load_v = load_val if load_val < MOD, else 0. Out-of-range loads give 0 and are not flagged.
  - en with q == MOD-1: t = q, so q becomes 0.
  - en otherwise: t[0]=1; t[i] = &q[i-1:0] for i ≥ 1 (binary increment).
  - idle: t = 0.
- Latency: q reflects load/increment on the edge where the request is sampled, and is visible in the following cycle.
- wrap ← en & ~load & ~rst & (q == MOD-1); otherwise 0. A load coinciding with terminal count suppresses wrap.
- tc is purely combinational. It is high whenever en=1 and q=MOD-1, regardless of load.
- MOD = 2^WIDTH: the wrap branch and the increment branch are equivalent (all ones to zero). The implementation must still use the wrap branch so the terminal compare is shared.
- Holding en=1 continuously: q runs 0,1,…,MOD-1,0,… with wrap high once every MOD cycles.
- Reset mid-count: the next cycle is q=0 and wrap=0, independent of en/load.
- q never leaves the range 0..MOD-1 after the first reset.
- Before the first reset, state is undefined; the bench must apply rst first.
- Elaboration check: MOD outside 2..2^WIDTH is a fatal error.

Decomposition:
- Shared counter package: the WIDTH/MOD legality check function, and a constant for the default width (4).
- Sub-module: tff_sync with ports clk, rst, t, q, q_bar.
  - Synchronous active-high reset to q=0.
  - On the edge, q ← q ^ t when rst=0.
  - Instantiated WIDTH times via generate, all on clk.
- Top module: T-vector logic, terminal compare, wrap register.

Test Plan:
1. Reset then count: rst=1 for 2 cycles, then en=1 for 20 cycles with WIDTH=4, MOD=16 → q = 0,1,…,15,0,1,2,3. wrap high exactly in the cycle q==0 following 15. tc high exactly when q==15.
2. Non-power-of-two modulus: WIDTH=4, MOD=10, en=1 for 25 cycles → q cycles 0..9. wrap pulses after each 9→0. q never shows 10–15.
3. Load and range clamp: load=1 with load_val=7 → q=7 next cycle. Then en for 3 cycles → 8,9,0 (MOD=10). load_val=12 → q=0.
4. Priority: rst=1, load=1, load_val=5, en=1 on the same edge → q=0, wrap=0. Next, load=1, load_val=3, en=1 with q=9 (MOD=10) → q=3, wrap=0, tc=1 during that cycle.
5. Enable gating: q=4, en=0 for 5 cycles → q holds 4, tc=0, wrap=0. Reassert en → q=5.
6. Cascade: two instances, WIDTH=4, MOD=10, stage-1 en = stage-0 tc, free-running → stage pair counts 00..99 then 00. Stage-1 wrap pulses once per 100 cycles.

Source files
------------

// File: rtl/sync_upcnt_tff_pkg.sv
// Shared definitions for the synchronous T-flip-flop counter family.
// Holds the default width and the WIDTH/MOD legality check.
package sync_upcnt_tff_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // A modulus is legal when 2 <= modv <= 2**width.
  function automatic bit mod_is_legal(input int width, input longint modv);
    if (width < 1 || width > 62) return 1'b0;
    return (modv >= 2) && (modv <= (longint'(1) << width));
  endfunction

endpackage

// File: rtl/sync_upcnt_tff_tff.sv
// Single T flip-flop cell with synchronous active-high reset.
// A cell toggles on the shared clock edge whenever t is high.
module tff_sync (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic q_bar
);

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= q ^ t;
  end

  assign q_bar = ~q;

endmodule

// File: rtl/sync_upcnt_tff.sv
// Synchronous modulo-MOD up counter built from T flip-flop cells on one clock.
// Provides enable, parallel load with range clamp, a cascade carry and a wrap pulse.
module sync_upcnt_tff
  import sync_upcnt_tff_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  if (!mod_is_legal(WIDTH, longint'(MOD))) begin : g_bad_mod
    $fatal(1, "sync_upcnt_tff: MOD must lie in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] TERM    = WIDTH'(MOD - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] load_v;
  logic [WIDTH-1:0] inc_t;
  logic [WIDTH-1:0] q_bar_unused;
  logic             at_term;
  logic             carry;

  // One shared terminal compare drives tc, the wrap branch and the wrap pulse.
  assign at_term = (q == TERM);
  assign tc      = en & at_term;

  // Out-of-range load values silently become 0.
  assign load_v = ({1'b0, load_val} < MOD_EXT) ? load_val : '0;

  // Toggle pattern for a binary increment: bit i toggles when all lower bits are 1.
  always_comb begin
    inc_t = '0;
    carry = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      inc_t[i] = carry;
      carry    = carry & q[i];
    end
  end

  always_comb begin
    t = '0;
    if (load) begin
      t = q ^ load_v;
    end else if (en) begin
      if (at_term) t = q;
      else         t = inc_t;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_sync u_tff (
      .clk   (clk),
      .rst   (rst),
      .t     (t[i]),
      .q     (q[i]),
      .q_bar (q_bar_unused[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= en & ~load & at_term;
  end

endmodule
